// File: rtl/vga_sprite_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vga_sprite_engine                                               |
// | Purpose  : VGA timing generator compositing flat-colour sprites over a     |
// |            background, with per-frame double-buffered sprite state.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module vga_sprite_engine #(
  parameter int          NUM_SPRITES = 5,
  parameter int          SPRITE_W    = 32,
  parameter int          SPRITE_H    = 32,
  parameter int          CLK_DIV     = 2,
  parameter int          H_ACTIVE    = 640,
  parameter int          H_FP        = 16,
  parameter int          H_SYNC      = 96,
  parameter int          H_BP        = 48,
  parameter int          V_ACTIVE    = 480,
  parameter int          V_FP        = 10,
  parameter int          V_SYNC      = 2,
  parameter int          V_BP        = 33,
  parameter logic [23:0] BG_COLOR    = 24'h70C5CE
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [10*NUM_SPRITES-1:0]   sprite_x,
  input  logic [10*NUM_SPRITES-1:0]   sprite_y,
  input  logic [NUM_SPRITES-1:0]      sprite_en,
  input  logic [24*NUM_SPRITES-1:0]   sprite_color,
  output logic                        vga_clk,
  output logic                        hsync,
  output logic                        vsync,
  output logic                        blank,
  output logic                        sync,
  output logic [7:0]                  vga_r,
  output logic [7:0]                  vga_g,
  output logic [7:0]                  vga_b,
  output logic                        frame_start,
  output logic                        collision
);

  localparam int         c_div_w    = $clog2(CLK_DIV);
  localparam logic [9:0] c_h_active = 10'(H_ACTIVE);
  localparam logic [9:0] c_v_active = 10'(V_ACTIVE);
  localparam logic [9:0] c_h_last   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] c_v_last   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] c_hs_start = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] c_hs_end   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] c_vs_start = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] c_vs_end   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [c_div_w-1:0]        r_div;
  logic [c_div_w-1:0]        w_div_next;
  logic                      r_vga_clk;
  logic                      w_pix_en;
  logic [9:0]                r_hcnt;
  logic [9:0]                r_vcnt;
  logic                      w_latch;

  logic [10*NUM_SPRITES-1:0] r_sh_x;
  logic [10*NUM_SPRITES-1:0] r_sh_y;
  logic [NUM_SPRITES-1:0]    r_sh_en;
  logic [24*NUM_SPRITES-1:0] r_sh_col;

  logic [NUM_SPRITES-1:0]    w_hit;
  logic                      w_vis;
  logic                      w_hs_n;
  logic                      w_vs_n;
  logic [NUM_SPRITES-1:0]    r_hit_s1;
  logic                      r_vis_s1;
  logic                      r_hs_s1;
  logic                      r_vs_s1;
  logic                      w_multi;
  logic [23:0]               w_color;
  logic [23:0]               r_rgb_s2;
  logic                      r_vis_s2;
  logic                      r_hs_s2;
  logic                      r_vs_s2;
  logic                      r_frame_start;
  logic                      r_coll_acc;
  logic                      r_collision;

  // Power-of-two divider: the MSB of the next count is the 50% duty pixel clock,
  // and pix_en is the count just before that MSB rises.
  assign w_div_next = r_div + c_div_w'(1);
  assign w_pix_en   = (r_div == c_div_w'(CLK_DIV / 2 - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div     <= '0;
      r_vga_clk <= 1'b0;
    end else begin
      r_div     <= w_div_next;
      r_vga_clk <= w_div_next[c_div_w-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (w_pix_en) begin
      if (r_hcnt == c_h_last) begin
        r_hcnt <= '0;
        r_vcnt <= (r_vcnt == c_v_last) ? '0 : r_vcnt + 10'd1;
      end else begin
        r_hcnt <= r_hcnt + 10'd1;
      end
    end
  end

  assign w_latch = w_pix_en && (r_hcnt == '0) && (r_vcnt == c_v_active);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_x   <= '0;
      r_sh_y   <= '0;
      r_sh_en  <= '0;
      r_sh_col <= '0;
    end else if (w_latch) begin
      r_sh_x   <= sprite_x;
      r_sh_y   <= sprite_y;
      r_sh_en  <= sprite_en;
      r_sh_col <= sprite_color;
    end
  end

  // Ten-bit subtraction wraps, so positions near 1023 sit partly off the left/top edge.
  for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_hit
    logic [9:0] w_dx;
    logic [9:0] w_dy;
    assign w_dx      = r_hcnt - r_sh_x[10*gi +: 10];
    assign w_dy      = r_vcnt - r_sh_y[10*gi +: 10];
    assign w_hit[gi] = r_sh_en[gi] && ({1'b0, w_dx} < 11'(SPRITE_W))
                                   && ({1'b0, w_dy} < 11'(SPRITE_H));
  end

  assign w_vis  = (r_hcnt < c_h_active) && (r_vcnt < c_v_active);
  assign w_hs_n = !((r_hcnt >= c_hs_start) && (r_hcnt < c_hs_end));
  assign w_vs_n = !((r_vcnt >= c_vs_start) && (r_vcnt < c_vs_end));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_s1 <= '0;
      r_vis_s1 <= 1'b0;
      r_hs_s1  <= 1'b1;
      r_vs_s1  <= 1'b1;
    end else if (w_pix_en) begin
      r_hit_s1 <= w_hit;
      r_vis_s1 <= w_vis;
      r_hs_s1  <= w_hs_n;
      r_vs_s1  <= w_vs_n;
    end
  end

  // Scanning from the top index down leaves the lowest hitting sprite on top.
  always_comb begin
    w_color = BG_COLOR;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (r_hit_s1[i]) w_color = r_sh_col[24*i +: 24];
    end
  end

  assign w_multi = |(r_hit_s1 & (r_hit_s1 - NUM_SPRITES'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rgb_s2 <= '0;
      r_vis_s2 <= 1'b0;
      r_hs_s2  <= 1'b1;
      r_vs_s2  <= 1'b1;
    end else if (w_pix_en) begin
      r_rgb_s2 <= r_vis_s1 ? w_color : 24'h0;
      r_vis_s2 <= r_vis_s1;
      r_hs_s2  <= r_hs_s1;
      r_vs_s2  <= r_vs_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_start <= 1'b0;
      r_coll_acc    <= 1'b0;
      r_collision   <= 1'b0;
    end else begin
      r_frame_start <= w_latch;
      if (w_latch) begin
        r_collision <= r_coll_acc;
        r_coll_acc  <= 1'b0;
      end else if (w_pix_en && r_vis_s1 && w_multi) begin
        r_coll_acc  <= 1'b1;
      end
    end
  end

  assign vga_clk     = r_vga_clk;
  assign hsync       = r_hs_s2;
  assign vsync       = r_vs_s2;
  assign blank       = r_vis_s2;
  assign sync        = 1'b0;
  assign vga_r       = r_rgb_s2[23:16];
  assign vga_g       = r_rgb_s2[15:8];
  assign vga_b       = r_rgb_s2[7:0];
  assign frame_start = r_frame_start;
  assign collision   = r_collision;

endmodule
`default_nettype wire

// File: tb/tb_vga_sprite_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_vga_sprite_engine                                            |
// | Purpose  : Reduced-geometry bench comparing every clk against a            |
// |            pixel-index reference model of the sprite display.              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_vga_sprite_engine;

  localparam int N   = 5;
  localparam int SW  = 8;
  localparam int SH  = 6;
  localparam int CD  = 2;
  localparam int HA  = 32, HFP = 4, HS = 4, HBP = 4;
  localparam int VA  = 16, VFP = 2, VS = 2, VBP = 2;
  localparam int HT  = HA + HFP + HS + HBP;
  localparam int VT  = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam logic [23:0] BG = 24'h70C5CE;

  logic          clk = 1'b0;
  logic          rst;
  logic [10*N-1:0] sprite_x;
  logic [10*N-1:0] sprite_y;
  logic [N-1:0]    sprite_en;
  logic [24*N-1:0] sprite_color;
  logic          vga_clk, hsync, vsync, blank, sync, frame_start, collision;
  logic [7:0]    vga_r, vga_g, vga_b;

  logic [9:0]    in_x   [N];
  logic [9:0]    in_y   [N];
  logic [23:0]   in_col [N];
  logic [N-1:0]  in_en;

  always #5 clk = ~clk;

  always_comb begin
    sprite_x     = '0;
    sprite_y     = '0;
    sprite_color = '0;
    for (int i = 0; i < N; i++) begin
      sprite_x[10*i +: 10]     = in_x[i];
      sprite_y[10*i +: 10]     = in_y[i];
      sprite_color[24*i +: 24] = in_col[i];
    end
    sprite_en = in_en;
  end

  vga_sprite_engine #(
    .NUM_SPRITES(N), .SPRITE_W(SW), .SPRITE_H(SH), .CLK_DIV(CD),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .BG_COLOR(BG)
  ) dut (
    .clk(clk), .rst(rst),
    .sprite_x(sprite_x), .sprite_y(sprite_y),
    .sprite_en(sprite_en), .sprite_color(sprite_color),
    .vga_clk(vga_clk), .hsync(hsync), .vsync(vsync), .blank(blank), .sync(sync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .frame_start(frame_start), .collision(collision)
  );

  // Reference model state: edges and pixel steps since reset, frame-latched sprites.
  int          n_edge, k;
  logic [9:0]  m_x [N];
  logic [9:0]  m_y [N];
  logic [23:0] m_col [N];
  logic [N-1:0] m_en;
  logic        m_acc, m_coll;
  logic        e_hs, e_vs, e_bl, e_fs, e_vclk;
  logic [23:0] e_rgb;
  int          st_bl, st_hs, st_vs, st_fs;
  int          errors, checks;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    n_edge = 0;
    k      = 0;
    for (int i = 0; i < N; i++) begin
      m_x[i] = '0; m_y[i] = '0; m_col[i] = '0;
    end
    m_en   = '0;
    m_acc  = 1'b0;
    m_coll = 1'b0;
    e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b0; e_rgb = '0; e_fs = 1'b0;
  endtask

  task automatic model_pixel(input int p);
    int idx, h, v, nh, dx, dy;
    logic [23:0] col;
    logic vis;
    idx  = p % FRAME;
    h    = idx % HT;
    v    = idx / HT;
    vis  = (h < HA) && (v < VA);
    e_bl = vis;
    e_hs = !(h >= HA + HFP && h < HA + HFP + HS);
    e_vs = !(v >= VA + VFP && v < VA + VFP + VS);
    nh   = 0;
    col  = BG;
    for (int i = N - 1; i >= 0; i--) begin
      dx = (h - int'(m_x[i]) + 1024) % 1024;
      dy = (v - int'(m_y[i]) + 1024) % 1024;
      if (m_en[i] && dx < SW && dy < SH) begin
        nh++;
        col = m_col[i];
      end
    end
    e_rgb = vis ? col : 24'h0;
    if (vis && nh >= 2) m_acc = 1'b1;
  endtask

  task automatic tick();
    bit pix;
    pix = 1'b0;
    @(posedge clk);
    e_fs = 1'b0;
    if (rst) begin
      model_reset();
    end else begin
      n_edge++;
      if ((n_edge - 1) % CD == CD / 2 - 1) begin
        pix = 1'b1;
        k++;
        if (k >= 2) model_pixel(k - 2);
        if ((k - 1) % FRAME == VA * HT) begin
          for (int i = 0; i < N; i++) begin
            m_x[i] = in_x[i]; m_y[i] = in_y[i]; m_col[i] = in_col[i];
          end
          m_en   = in_en;
          m_coll = m_acc;
          m_acc  = 1'b0;
          e_fs   = 1'b1;
        end
      end
    end
    e_vclk = ((n_edge % CD) >= CD / 2);
    #1;
    check_eq("pix", {vga_clk, hsync, vsync, blank, sync, frame_start, collision, vga_r, vga_g, vga_b},
                    {e_vclk, e_hs, e_vs, e_bl, 1'b0, e_fs, m_coll, e_rgb});
    if (pix) begin
      st_bl += int'(blank);
      st_hs += int'(!hsync);
      st_vs += int'(!vsync);
    end
    st_fs += int'(frame_start);
  endtask

  task automatic run_frame(input bit with_stats);
    st_bl = 0; st_hs = 0; st_vs = 0; st_fs = 0;
    repeat (FRAME * CD) tick();
    if (with_stats) begin
      check_eq("blank_cnt", st_bl, HA * VA);
      check_eq("hsync_cnt", st_hs, HS * VT);
      check_eq("vsync_cnt", st_vs, VS * HT);
      check_eq("fs_cnt", st_fs, 1);
    end
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < N; i++) begin
      in_x[i] = '0; in_y[i] = '0; in_col[i] = '0;
    end
    in_en = '0;
  endtask

  function automatic logic [9:0] rand_pos(input int lim, input int sz);
    if ($urandom_range(0, 3) == 0) return 10'(1024 - int'($urandom_range(1, sz)));
    return 10'($urandom_range(0, lim));
  endfunction

  task automatic set_scenario(input int sc);
    case (sc)
      0: begin clear_inputs(); in_en[0] = 1'b1; in_x[0] = 10'd10; in_y[0] = 10'd5; in_col[0] = 24'hFF0000; end
      1: begin in_x[0] = 10'd1020; in_y[0] = 10'd1022; end
      2: begin in_x[0] = 10'(HA - 3); in_y[0] = 10'd8; end
      3: begin
        clear_inputs();
        in_en[1] = 1'b1; in_x[1] = 10'd12; in_y[1] = 10'd4; in_col[1] = 24'h00FF00;
        in_en[3] = 1'b1; in_x[3] = 10'd15; in_y[3] = 10'd6; in_col[3] = 24'h0000FF;
      end
      4: begin in_x[3] = 10'd24; in_y[3] = 10'd10; end
      default: begin
        for (int i = 0; i < N; i++) begin
          in_en[i]  = 1'($urandom_range(0, 1));
          in_x[i]   = rand_pos(HA, SW);
          in_y[i]   = rand_pos(VA, SH);
          in_col[i] = 24'($urandom);
        end
      end
    endcase
  endtask

  initial begin
    int target;
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    clear_inputs();
    model_reset();
    repeat (3) tick();
    check_eq("rst_out", {vga_clk, hsync, vsync, blank, sync, frame_start, collision, vga_r, vga_g, vga_b},
                        {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0});
    rst = 1'b0;
    set_scenario(0);
    run_frame(1'b1);

    for (int sc = 0; sc < 11; sc++) begin
      repeat ($urandom_range(0, FRAME * CD / 2)) tick();
      set_scenario(sc);
      run_frame(1'b0);
      run_frame(1'b1);
      if (sc == 3) check_eq("coll_set", collision, 1'b1);
      if (sc == 4) check_eq("coll_clr", collision, 1'b0);
    end

    // Reset in the middle of the visible area, with sprites still enabled at the inputs.
    target = (VA / 2) * HT + 5;
    for (int t = 0; t < FRAME * CD && (k % FRAME) != target; t++) tick();
    check_eq("rst_reach", (k % FRAME), target);
    rst = 1'b1;
    tick();
    check_eq("midrst_out", {vga_clk, hsync, vsync, blank, sync, frame_start, collision, vga_r, vga_g, vga_b},
                           {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0});
    rst = 1'b0;
    set_scenario(5);
    run_frame(1'b1);
    run_frame(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
